// File: rtl/mem_access_stage.sv
// Shared pipeline widths, followed by the memory-access stage.
// The stage issues EX/MEM loads and stores over a req/ack handshake.
// It stalls upstream while an access is outstanding.
// A watchdog turns a lost acknowledge into a one-cycle error pulse.
package defines;
  localparam int WORD_LEN          = 32;
  localparam int REG_FILE_ADDR_LEN = 5;
endpackage

module mem_access_stage #(
  parameter int WORD_LEN          = defines::WORD_LEN,
  parameter int REG_FILE_ADDR_LEN = defines::REG_FILE_ADDR_LEN,
  parameter int TIMEOUT_CYCLES    = 16
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         WB_EN_IN,
  input  logic                         MEM_R_EN_IN,
  input  logic                         MEM_W_EN_IN,
  input  logic [REG_FILE_ADDR_LEN-1:0] destIn,
  input  logic [WORD_LEN-1:0]          ALUResIn,
  input  logic [WORD_LEN-1:0]          storeValIn,
  output logic                         WB_EN,
  output logic                         MEM_R_EN,
  output logic [REG_FILE_ADDR_LEN-1:0] dest,
  output logic [WORD_LEN-1:0]          ALURes,
  output logic [WORD_LEN-1:0]          memReadVal,
  output logic                         stall,
  output logic                         mem_req,
  output logic                         mem_we,
  output logic [WORD_LEN-1:0]          mem_addr,
  output logic [WORD_LEN-1:0]          mem_wdata,
  input  logic [WORD_LEN-1:0]          mem_rdata,
  input  logic                         mem_ack,
  output logic                         mem_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int               CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                req_q, req_d;
  logic                we_q, we_d;
  logic [WORD_LEN-1:0] addr_q, addr_d;
  logic [WORD_LEN-1:0] wdata_q, wdata_d;
  logic                err_q, err_d;
  logic [WORD_LEN-1:0] rdata_q, rdata_d;
  logic                op_s;
  logic                stall_s;

  assign op_s = MEM_R_EN_IN | MEM_W_EN_IN;

  // Next-state logic: issue, watchdog countdown and completion capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = 1'b0;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (op_s) begin
          addr_d  = ALUResIn;
          wdata_d = storeValIn;
          we_d    = MEM_W_EN_IN;
          req_d   = 1'b1;
          cnt_d   = {CNT_W{1'b0}};
          state_d = S_BUSY;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        // Ack is checked first so a last-cycle ack beats the timeout.
        if (mem_ack) begin
          if (!we_q) begin
            rdata_d = mem_rdata;
          end else begin
            rdata_d = rdata_q;
          end
          req_d   = 1'b0;
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          // An aborted load writes back zero; an aborted store is dropped.
          rdata_d = {WORD_LEN{1'b0}};
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= {WORD_LEN{1'b0}};
      wdata_q <= {WORD_LEN{1'b0}};
      err_q   <= 1'b0;
      rdata_q <= {WORD_LEN{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Stall request: the issue cycle and every BUSY cycle; held low during reset.
  always_comb begin
    stall_s = 1'b0;
    case (state_q)
      S_IDLE:  stall_s = op_s;
      S_BUSY:  stall_s = 1'b1;
      S_DONE:  stall_s = 1'b0;
      default: stall_s = 1'b0;
    endcase
  end

  // MEM/WB-facing outputs: pass-through, or a bubble while stalled.
  always_comb begin
    stall      = stall_s & rstn;
    dest       = destIn;
    ALURes     = ALUResIn;
    memReadVal = rdata_q;
    if (rstn && !stall_s) begin
      WB_EN    = WB_EN_IN;
      MEM_R_EN = (state_q == S_DONE) ? MEM_R_EN_IN : 1'b0;
    end else begin
      WB_EN    = 1'b0;
      MEM_R_EN = 1'b0;
    end
  end

  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_err   = err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with a short watchdog (4 cycles).
module tb_mem_access_stage;

  logic        clk;
  logic        rstn;
  logic        WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN;
  logic [4:0]  destIn;
  logic [31:0] ALUResIn, storeValIn;
  logic        WB_EN, MEM_R_EN;
  logic [4:0]  dest;
  logic [31:0] ALURes, memReadVal;
  logic        stall, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack, mem_err;

  int n_cmp = 0;
  int n_bad = 0;

  mem_access_stage #(.WORD_LEN(32), .REG_FILE_ADDR_LEN(5), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rstn(rstn),
    .WB_EN_IN(WB_EN_IN), .MEM_R_EN_IN(MEM_R_EN_IN), .MEM_W_EN_IN(MEM_W_EN_IN),
    .destIn(destIn), .ALUResIn(ALUResIn), .storeValIn(storeValIn),
    .WB_EN(WB_EN), .MEM_R_EN(MEM_R_EN), .dest(dest), .ALURes(ALURes),
    .memReadVal(memReadVal), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_err(mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wb;
    logic [4:0]  dst;
    logic [31:0] alu;
    logic        exp_wb;
    logic [4:0]  exp_dst;
    logic [31:0] exp_alu;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic wb, input logic rd, input logic wr,
                        input logic [4:0] d, input logic [31:0] a, input logic [31:0] s);
    WB_EN_IN = wb; MEM_R_EN_IN = rd; MEM_W_EN_IN = wr;
    destIn = d; ALUResIn = a; storeValIn = s;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int req_cnt;
    vecs[0] = '{1'b1, 5'd5,  32'h0000_1234, 1'b1, 5'd5,  32'h0000_1234};
    vecs[1] = '{1'b0, 5'd31, 32'hFFFF_FFFF, 1'b0, 5'd31, 32'hFFFF_FFFF};
    vecs[2] = '{1'b1, 5'd0,  32'h0000_0000, 1'b1, 5'd0,  32'h0000_0000};
    vecs[3] = '{1'b1, 5'd17, 32'h8000_0001, 1'b1, 5'd17, 32'h8000_0001};

    rstn = 1'b0; mem_ack = 1'b0; mem_rdata = 32'h0;
    set_in(1'b1, 1'b0, 1'b0, 5'd3, 32'h0, 32'h0);
    tick(); tick();
    #1;
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_err", {31'd0, mem_err}, 32'd0);
    chk("rst_stall",   {31'd0, stall},   32'd0);
    chk("rst_wb_en",   {31'd0, WB_EN},   32'd0);
    chk("rst_addr",    mem_addr,         32'd0);
    chk("rst_rdval",   memReadVal,       32'd0);
    rstn = 1'b1;
    tick();

    // Pass-through vectors: no memory op, zero latency.
    for (int i = 0; i < 4; i++) begin
      set_in(vecs[i].wb, 1'b0, 1'b0, vecs[i].dst, vecs[i].alu, 32'h0);
      #1;
      chk("pt_stall",  {31'd0, stall},    32'd0);
      chk("pt_wb_en",  {31'd0, WB_EN},    {31'd0, vecs[i].exp_wb});
      chk("pt_dest",   {27'd0, dest},     {27'd0, vecs[i].exp_dst});
      chk("pt_alures", ALURes,            vecs[i].exp_alu);
      chk("pt_memr",   {31'd0, MEM_R_EN}, 32'd0);
      tick();
      chk("pt_req",    {31'd0, mem_req},  32'd0);
    end

    // Load acked on the second BUSY cycle.
    set_in(1'b1, 1'b1, 1'b0, 5'd7, 32'h40, 32'h0);
    #1;
    chk("ld_c0_stall", {31'd0, stall}, 32'd1);
    chk("ld_c0_wb",    {31'd0, WB_EN}, 32'd0);
    tick();
    chk("ld_c1_req",   {31'd0, mem_req}, 32'd1);
    chk("ld_c1_addr",  mem_addr,         32'h40);
    chk("ld_c1_we",    {31'd0, mem_we},  32'd0);
    chk("ld_c1_stall", {31'd0, stall},   32'd1);
    chk("ld_c1_wb",    {31'd0, WB_EN},   32'd0);
    tick();
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("ld_c2_req",   {31'd0, mem_req}, 32'd1);
    chk("ld_c2_stall", {31'd0, stall},   32'd1);
    chk("ld_c2_addr",  mem_addr,         32'h40);
    tick();
    mem_ack = 1'b0;
    #1;
    chk("ld_done_stall", {31'd0, stall},    32'd0);
    chk("ld_done_rd",    memReadVal,        32'hDEAD_BEEF);
    chk("ld_done_memr",  {31'd0, MEM_R_EN}, 32'd1);
    chk("ld_done_wb",    {31'd0, WB_EN},    32'd1);
    chk("ld_done_dest",  {27'd0, dest},     32'd7);
    chk("ld_done_req",   {31'd0, mem_req},  32'd0);
    chk("ld_done_err",   {31'd0, mem_err},  32'd0);
    tick();

    // Store acked on the first BUSY cycle, back-to-back after the load.
    set_in(1'b0, 1'b0, 1'b1, 5'd0, 32'h80, 32'hA5A5_A5A5);
    #1;
    chk("st_c0_stall", {31'd0, stall}, 32'd1);
    tick();
    mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
    #1;
    chk("st_c1_req",   {31'd0, mem_req}, 32'd1);
    chk("st_c1_we",    {31'd0, mem_we},  32'd1);
    chk("st_c1_wdata", mem_wdata,        32'hA5A5_A5A5);
    chk("st_c1_addr",  mem_addr,         32'h80);
    tick();
    mem_ack = 1'b0;
    #1;
    chk("st_done_stall", {31'd0, stall},    32'd0);
    chk("st_done_rd",    memReadVal,        32'hDEAD_BEEF);
    chk("st_done_memr",  {31'd0, MEM_R_EN}, 32'd0);
    chk("st_done_err",   {31'd0, mem_err},  32'd0);
    tick();

    // Load with no ack: watchdog abort after 4 BUSY cycles.
    set_in(1'b1, 1'b1, 1'b0, 5'd9, 32'h44, 32'h0);
    tick();
    req_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (!stall) break;
      if (mem_req) req_cnt++;
      tick();
    end
    chk("to_req_cycles", req_cnt,            32'd4);
    chk("to_stall",      {31'd0, stall},     32'd0);
    chk("to_err",        {31'd0, mem_err},   32'd1);
    chk("to_rd",         memReadVal,         32'd0);
    chk("to_memr",       {31'd0, MEM_R_EN},  32'd1);
    set_in(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    tick();
    chk("to_err_pulse",  {31'd0, mem_err},   32'd0);

    // Ack coincides with the final BUSY cycle: ack wins.
    set_in(1'b1, 1'b1, 1'b0, 5'd4, 32'h48, 32'h0);
    tick(); tick(); tick(); tick();
    mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
    #1;
    chk("la_c4_req",   {31'd0, mem_req}, 32'd1);
    chk("la_c4_stall", {31'd0, stall},   32'd1);
    tick();
    mem_ack = 1'b0;
    #1;
    chk("la_err",   {31'd0, mem_err}, 32'd0);
    chk("la_rd",    memReadVal,       32'hCAFE_F00D);
    chk("la_stall", {31'd0, stall},   32'd0);
    tick();

    // Reset during BUSY, then a stray ack.
    set_in(1'b1, 1'b1, 1'b0, 5'd2, 32'h4C, 32'h0);
    tick();
    chk("rm_busy_req", {31'd0, mem_req}, 32'd1);
    rstn = 1'b0;
    tick();
    chk("rm_req",   {31'd0, mem_req}, 32'd0);
    chk("rm_stall", {31'd0, stall},   32'd0);
    chk("rm_wb",    {31'd0, WB_EN},   32'd0);
    rstn = 1'b1;
    set_in(1'b1, 1'b0, 1'b0, 5'd6, 32'h99, 32'h0);
    tick();
    mem_ack = 1'b1; mem_rdata = 32'h0000_0099;
    tick();
    mem_ack = 1'b0;
    #1;
    chk("rm_stray_rd",    memReadVal,       32'd0);
    chk("rm_stray_req",   {31'd0, mem_req}, 32'd0);
    chk("rm_stray_stall", {31'd0, stall},   32'd0);
    chk("rm_stray_err",   {31'd0, mem_err}, 32'd0);
    chk("rm_stray_wb",    {31'd0, WB_EN},   32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access stage of the five-stage pipeline, sitting between the EX/MEM pipeline register and the MEM/WB pipeline register. It issues loads and stores from the EX/MEM register to a variable-latency data memory over a req/ack handshake, stalls the upstream pipeline while an access is outstanding, and presents the load result and control bits to the MEM/WB register. A watchdog converts a lost acknowledge into an error pulse instead of a permanent hang.

## Interface
- WORD_LEN, default `defines::WORD_LEN`: data and address width.
- REG_FILE_ADDR_LEN, default `defines::REG_FILE_ADDR_LEN`: destination register index width.
- TIMEOUT_CYCLES, default 16: maximum number of BUSY cycles before abort; must be ≥ 2.

Ports:
- clk, input, 1: clock; all state updates on posedge.
- rstn, input, 1: reset, synchronous, active-low.
- WB_EN_IN, input, 1: write-back enable from EX/MEM.
- MEM_R_EN_IN, input, 1: load from EX/MEM.
- MEM_W_EN_IN, input, 1: store from EX/MEM. Never asserted together with MEM_R_EN_IN.
- destIn, input, REG_FILE_ADDR_LEN: destination register.
- ALUResIn, input, WORD_LEN: ALU result; this is the memory address for loads and stores.
- storeValIn, input, WORD_LEN: store data.
- WB_EN, MEM_R_EN, output, 1: to MEM/WB.
- dest, output, REG_FILE_ADDR_LEN: to MEM/WB.
- ALURes, memReadVal, output, WORD_LEN: to MEM/WB.
- stall, output, 1: freeze PC, IF/ID, ID/EX and EX/MEM this cycle.
- mem_req, output, 1: access request to memory; registered.
- mem_we, output, 1: 1 for a store, 0 for a load; registered.
- mem_addr, mem_wdata, output, WORD_LEN: registered address and write data.
- mem_rdata, input, WORD_LEN: read data; valid with mem_ack.
- mem_ack, input, 1: access complete.
- mem_err, output, 1: one-cycle pulse on timeout abort; registered.

## Operation
- FSM states: IDLE, BUSY, DONE. Let `op = MEM_R_EN_IN | MEM_W_EN_IN`.
- **IDLE, op=0:**
  - stall=0.
  - Outputs pass through: WB_EN=WB_EN_IN, MEM_R_EN=0, dest=destIn, ALURes=ALUResIn, memReadVal=rdata_q.
- **IDLE, op=1:**
  - stall=1.
  - Capture mem_addr←ALUResIn, mem_wdata←storeValIn, mem_we←MEM_W_EN_IN.
  - Set mem_req←1, clear the watchdog counter, go to BUSY.
- **BUSY:**
  - stall=1, mem_req held at 1.
  - mem_ack=1: rdata_q←mem_rdata on a load (a store leaves rdata_q unchanged), mem_req←0, go to DONE.
  - mem_ack=0 with counter = TIMEOUT_CYCLES-1: rdata_q←0, mem_req←0, mem_err←1 for one cycle, go to DONE.
  - Otherwise the counter increments.
- **DONE:**
  - stall=0.
  - Outputs: WB_EN=WB_EN_IN, MEM_R_EN=MEM_R_EN_IN, dest=destIn, ALURes=ALUResIn, memReadVal=rdata_q.
  - Next state is IDLE unconditionally; the pipeline advances on this edge.
- **Bubble rule:** whenever stall=1, WB_EN=0 and MEM_R_EN=0, so MEM/WB captures a bubble.
- mem_ack outside BUSY is ignored.
- Ack and timeout in the same cycle: the ack wins and mem_err stays 0.
- An aborted store is dropped. An aborted load writes back 0.
- mem_addr, mem_wdata and mem_we are stable for the whole time mem_req=1.
- **Reset** (rstn=0 at a posedge, including mid-access): state←IDLE, mem_req←0, mem_we←0, mem_addr←0, mem_wdata←0, mem_err←0, counter←0, rdata_q←0.
  - While rstn=0, stall, WB_EN and MEM_R_EN are forced to 0.
  - A pending ack after reset is ignored.

## Timing
- A non-memory instruction takes 1 cycle in the stage with zero added latency.
- A memory access with ack in the first BUSY cycle takes 3 cycles:
  - cycle 0: IDLE, stall=1.
  - cycle 1: BUSY, mem_req=1, ack.
  - cycle 2: DONE, stall=0, MEM/WB captures at the end of the cycle.
- General occupancy is 3+N cycles, where N is the number of BUSY cycles before ack.
- Maximum occupancy is TIMEOUT_CYCLES+2 cycles.
- mem_err is asserted during the DONE cycle only.
- Back-to-back memory ops have no idle gap beyond DONE→IDLE: the next op is seen in IDLE on the following cycle.

## Test plan
- **Pass-through:** ADD with WB_EN_IN=1, destIn=5, ALUResIn=0x1234 → same cycle stall=0, WB_EN=1, dest=5, ALURes=0x1234, mem_req never asserted.
- **Load, ack after 2 BUSY cycles:** mem_rdata=0xDEADBEEF, ALUResIn=0x40 → mem_addr=0x40 and mem_we=0 while mem_req=1. stall=1 for 3 cycles with WB_EN=0. In DONE, memReadVal=0xDEADBEEF, MEM_R_EN=1, stall=0.
- **Store, ack in the first BUSY cycle:** storeValIn=0xA5A5A5A5 → mem_we=1, mem_wdata=0xA5A5A5A5. DONE on the 3rd cycle, memReadVal unchanged.
- **Timeout with TIMEOUT_CYCLES=4, no ack:** mem_req high for exactly 4 cycles. mem_err pulses 1 cycle in DONE, load memReadVal=0.
- **Ack on the final BUSY cycle:** ack coincides with counter=3 → mem_err=0, read data delivered.
- **Reset mid-access:** rstn=0 during BUSY → next cycle mem_req=0, stall=0, state IDLE. A later stray mem_ack has no effect.
